exec_core: RTL and testbench

EXEC_CORE -- requirements
Module: exec_core

---
 rtl/exec_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_exec_core.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_core.sv
// Single-cycle MIPS32 execute stage: instruction decode, ALU with flags, and a
// small CP0 block (Status/Cause/EPC) handling mtc0/mfc0, syscall and eret.
module exec_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] pc,
    output logic [31:0] alu_res,
    output logic        zero,
    output logic        great,
    output logic        overflow,
    output logic [3:0]  pc_op,
    output logic [1:0]  reg_src,
    output logic [1:0]  reg_dst,
    output logic        reg_wr,
    output logic        reg_in,
    output logic        dm_wr,
    output logic        dm_rd,
    output logic [2:0]  dm_op,
    output logic [31:0] cop_data
);
    localparam logic [31:0] ERET = 32'h4200_0018;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } alu_op_e;
    typedef enum logic [1:0] {IMM_NONE, IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_e;
    typedef enum logic [1:0] {COP_ZERO, COP_CP0, COP_VEC, COP_EPC} cop_e;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs_f, rd_f, shamt;
    alu_op_e     alu_op;
    imm_e        imm_sel;
    cop_e        cop_sel;
    logic        shift_var, ovf_chk, wr_dec, r_alu, i_alu;
    logic        cp0_wr, is_sys, is_eret;
    logic [31:0] op_b, sum, diff, cp0_rdata;
    logic [4:0]  sh_amt;
    logic        ovf_raw;
    logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;

    assign opcode = ins[31:26];
    assign rs_f   = ins[25:21];
    assign rd_f   = ins[15:11];
    assign shamt  = ins[10:6];
    assign funct  = ins[5:0];

    always_comb begin
        alu_op    = ALU_ADD;
        imm_sel   = IMM_NONE;
        cop_sel   = COP_ZERO;
        shift_var = 1'b0;
        ovf_chk   = 1'b0;
        wr_dec    = 1'b0;
        r_alu     = 1'b0;
        i_alu     = 1'b0;
        cp0_wr    = 1'b0;
        is_sys    = 1'b0;
        is_eret   = 1'b0;
        pc_op     = 4'd0;
        reg_src   = 2'd0;
        reg_dst   = 2'd0;
        reg_in    = 1'b0;
        dm_wr     = 1'b0;
        dm_rd     = 1'b0;
        dm_op     = 3'd0;
        case (opcode)
            6'h00: begin
                r_alu = 1'b1;
                case (funct)
                    6'h00: alu_op = ALU_SLL;
                    6'h02: alu_op = ALU_SRL;
                    6'h03: alu_op = ALU_SRA;
                    6'h04: begin alu_op = ALU_SLL; shift_var = 1'b1; end
                    6'h06: begin alu_op = ALU_SRL; shift_var = 1'b1; end
                    6'h07: begin alu_op = ALU_SRA; shift_var = 1'b1; end
                    6'h20: begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
                    6'h21: alu_op = ALU_ADD;
                    6'h22: begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
                    6'h23: alu_op = ALU_SUB;
                    6'h24: alu_op = ALU_AND;
                    6'h25: alu_op = ALU_OR;
                    6'h26: alu_op = ALU_XOR;
                    6'h27: alu_op = ALU_NOR;
                    6'h2A: alu_op = ALU_SLT;
                    6'h2B: alu_op = ALU_SLTU;
                    6'h08: begin r_alu = 1'b0; pc_op = 4'd6; end
                    6'h09: begin r_alu = 1'b0; pc_op = 4'd6; wr_dec = 1'b1; end
                    6'h0C: begin
                        r_alu   = 1'b0;
                        pc_op   = 4'd7;
                        cop_sel = COP_VEC;
                        is_sys  = 1'b1;
                    end
                    default: r_alu = 1'b0;
                endcase
                if (r_alu) begin
                    reg_src = 2'd1;
                    wr_dec  = 1'b1;
                end
            end
            6'h02: pc_op = 4'd5;
            6'h03: begin pc_op = 4'd5; reg_dst = 2'd2; wr_dec = 1'b1; end
            6'h04: pc_op = 4'd1;
            6'h05: pc_op = 4'd2;
            6'h06: begin pc_op = 4'd4; reg_in = 1'b1; end
            6'h07: begin pc_op = 4'd3; reg_in = 1'b1; end
            6'h08: begin imm_sel = IMM_SEXT; ovf_chk = 1'b1; i_alu = 1'b1; end
            6'h09: begin imm_sel = IMM_SEXT; i_alu = 1'b1; end
            6'h0A: begin imm_sel = IMM_SEXT; alu_op = ALU_SLT;   i_alu = 1'b1; end
            6'h0B: begin imm_sel = IMM_SEXT; alu_op = ALU_SLTU;  i_alu = 1'b1; end
            6'h0C: begin imm_sel = IMM_ZEXT; alu_op = ALU_AND;   i_alu = 1'b1; end
            6'h0D: begin imm_sel = IMM_ZEXT; alu_op = ALU_OR;    i_alu = 1'b1; end
            6'h0E: begin imm_sel = IMM_ZEXT; alu_op = ALU_XOR;   i_alu = 1'b1; end
            6'h0F: begin imm_sel = IMM_LUI;  alu_op = ALU_PASSB; i_alu = 1'b1; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                imm_sel = IMM_SEXT;
                dm_rd   = 1'b1;
                reg_src = 2'd2;
                reg_dst = 2'd1;
                wr_dec  = 1'b1;
                // opcode low bits pick width/signedness: lb lh lw lbu lhu
                case (opcode[2:0])
                    3'd0:    dm_op = 3'd1;
                    3'd1:    dm_op = 3'd3;
                    3'd4:    dm_op = 3'd2;
                    3'd5:    dm_op = 3'd4;
                    default: dm_op = 3'd0;
                endcase
            end
            6'h28, 6'h29, 6'h2B: begin
                imm_sel = IMM_SEXT;
                dm_wr   = 1'b1;
                case (opcode[1:0])
                    2'd0:    dm_op = 3'd1;
                    2'd1:    dm_op = 3'd3;
                    default: dm_op = 3'd0;
                endcase
            end
            6'h10: begin
                if (ins == ERET) begin
                    pc_op   = 4'd7;
                    cop_sel = COP_EPC;
                    is_eret = 1'b1;
                end else if (rs_f == 5'd0) begin
                    cop_sel = COP_CP0;
                    reg_src = 2'd3;
                    reg_dst = 2'd1;
                    wr_dec  = 1'b1;
                end else if (rs_f == 5'd4) begin
                    cp0_wr = 1'b1;
                end
            end
            default: ;
        endcase
        if (i_alu) begin
            reg_src = 2'd1;
            reg_dst = 2'd1;
            wr_dec  = 1'b1;
        end
    end

    always_comb begin
        case (imm_sel)
            IMM_SEXT: op_b = {{16{ins[15]}}, ins[15:0]};
            IMM_ZEXT: op_b = {16'h0000, ins[15:0]};
            IMM_LUI:  op_b = {ins[15:0], 16'h0000};
            default:  op_b = rt_data;
        endcase
    end

    assign sum    = rs_data + op_b;
    assign diff   = rs_data - op_b;
    assign sh_amt = shift_var ? rs_data[4:0] : shamt;
    assign ovf_raw = (alu_op == ALU_SUB)
                   ? ((rs_data[31] != op_b[31]) && (diff[31] != rs_data[31]))
                   : ((rs_data[31] == op_b[31]) && (sum[31]  != rs_data[31]));
    assign overflow = ovf_chk & ovf_raw;
    assign reg_wr   = wr_dec & ~overflow;
    assign zero     = (rs_data == op_b);
    assign great    = ($signed(rs_data) > $signed(op_b));

    always_comb begin
        case (alu_op)
            ALU_ADD:   alu_res = sum;
            ALU_SUB:   alu_res = diff;
            ALU_AND:   alu_res = rs_data & op_b;
            ALU_OR:    alu_res = rs_data | op_b;
            ALU_XOR:   alu_res = rs_data ^ op_b;
            ALU_NOR:   alu_res = ~(rs_data | op_b);
            ALU_SLT:   alu_res = {31'd0, $signed(rs_data) < $signed(op_b)};
            ALU_SLTU:  alu_res = {31'd0, rs_data < op_b};
            ALU_SLL:   alu_res = op_b << sh_amt;
            ALU_SRL:   alu_res = op_b >> sh_amt;
            ALU_SRA:   alu_res = $signed(op_b) >>> sh_amt;
            default:   alu_res = op_b;
        endcase
    end

    always_comb begin
        case (rd_f)
            5'd12:   cp0_rdata = status_q;
            5'd13:   cp0_rdata = cause_q;
            5'd14:   cp0_rdata = epc_q;
            default: cp0_rdata = 32'd0;
        endcase
        case (cop_sel)
            COP_CP0: cop_data = cp0_rdata;
            COP_VEC: cop_data = 32'h0000_0080;
            COP_EPC: cop_data = epc_q;
            default: cop_data = 32'd0;
        endcase
    end

    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        if (cp0_wr) begin
            case (rd_f)
                5'd12:   status_d = rt_data;
                5'd13:   cause_d  = rt_data;
                5'd14:   epc_d    = rt_data;
                default: ;
            endcase
        end
        if (is_sys) begin
            epc_d        = pc;
            cause_d[6:2] = 5'd8;
            status_d[1]  = 1'b1;
        end
        if (is_eret) status_d[1] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= 32'd0;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end
endmodule

// File: tb/tb_exec_core.sv
// Bench for exec_core: fixed vectors, CP0 sequences, then random instructions
// compared against an instruction-level reference model.
module tb_exec_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins, rs_data, rt_data, pc;
    logic [31:0] alu_res, cop_data;
    logic        zero, great, overflow, reg_wr, reg_in, dm_wr, dm_rd;
    logic [3:0]  pc_op;
    logic [1:0]  reg_src, reg_dst;
    logic [2:0]  dm_op;

    localparam logic [31:0] ERET = 32'h4200_0018;
    localparam longint MAXI = 2147483647;
    localparam longint MINI = -MAXI - 1;

    exec_core dut (
        .clk(clk), .rst(rst), .ins(ins), .rs_data(rs_data), .rt_data(rt_data), .pc(pc),
        .alu_res(alu_res), .zero(zero), .great(great), .overflow(overflow),
        .pc_op(pc_op), .reg_src(reg_src), .reg_dst(reg_dst), .reg_wr(reg_wr),
        .reg_in(reg_in), .dm_wr(dm_wr), .dm_rd(dm_rd), .dm_op(dm_op), .cop_data(cop_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] ins, rs, rt, alu;
        logic        ck_alu, zero, great, ovf;
        logic [3:0]  pc_op;
        logic [1:0]  src;
        logic        wr, rin, dmr, dmw;
    } vec_t;

    typedef struct packed {
        logic [31:0] alu, cop;
        logic        ck_alu, ck_cop, zero, great, ovf, wr, rin, dmr, dmw;
        logic [3:0]  pc_op;
        logic [1:0]  src, dst;
        logic [2:0]  dmop;
    } exp_t;

    logic [31:0] m_cp0 [12:14];

    logic [5:0] r_fns [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                               6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C};
    logic [5:0] i_ops [22] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                               6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    logic [5:0] bad_fns [4] = '{6'h01, 6'h05, 6'h0A, 6'h3F};
    logic [5:0] bad_ops [4] = '{6'h01, 6'h11, 6'h3F, 6'h2F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p);
        @(negedge clk);
        rst = r; ins = i; rs_data = a; rt_data = b; pc = p;
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] enc_cop(input logic [4:0] s, input logic [4:0] d);
        return {6'h10, s, 5'd2, d, 11'd0};
    endfunction

    function automatic vec_t mkv(input logic [31:0] i, a, b, alu, input logic ck,
                                 input logic z, g, o, input logic [3:0] pco,
                                 input logic [1:0] src, input logic wr, rin, dmr, dmw);
        vec_t v;
        v.ins = i; v.rs = a; v.rt = b; v.alu = alu; v.ck_alu = ck;
        v.zero = z; v.great = g; v.ovf = o; v.pc_op = pco; v.src = src;
        v.wr = wr; v.rin = rin; v.dmr = dmr; v.dmw = dmw;
        return v;
    endfunction

    function automatic logic [31:0] cp0_read(input logic [4:0] n);
        if (n == 5'd12) return m_cp0[12];
        if (n == 5'd13) return m_cp0[13];
        if (n == 5'd14) return m_cp0[14];
        return 32'd0;
    endfunction

    function automatic logic ovf_of(input longint s);
        return (s > MAXI) || (s < MINI);
    endfunction

    // Instruction-level reference: what each mnemonic means, not how it is decoded.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] rt);
        exp_t e;
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        logic [31:0] sx, b;
        logic        ralu, ialu;
        op = i[31:26]; fn = i[5:0]; sh = i[10:6];
        sx = {{16{i[15]}}, i[15:0]};
        e = '0; b = rt; ralu = 1'b0; ialu = 1'b0;
        if (op == 6'h00) begin
            ralu = 1'b1;
            case (fn)
                6'h20: begin e.alu = a + b; e.ovf = ovf_of(longint'($signed(a)) + longint'($signed(b))); end
                6'h21: e.alu = a + b;
                6'h22: begin e.alu = a - b; e.ovf = ovf_of(longint'($signed(a)) - longint'($signed(b))); end
                6'h23: e.alu = a - b;
                6'h24: e.alu = a & b;
                6'h25: e.alu = a | b;
                6'h26: e.alu = a ^ b;
                6'h27: e.alu = ~(a | b);
                6'h2A: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: e.alu = (a < b) ? 32'd1 : 32'd0;
                6'h00: e.alu = b << sh;
                6'h02: e.alu = b >> sh;
                6'h03: e.alu = 32'(longint'($signed(b)) >>> sh);
                6'h04: e.alu = b << a[4:0];
                6'h06: e.alu = b >> a[4:0];
                6'h07: e.alu = 32'(longint'($signed(b)) >>> a[4:0]);
                6'h08: begin ralu = 1'b0; e.pc_op = 4'd6; end
                6'h09: begin ralu = 1'b0; e.pc_op = 4'd6; e.wr = 1'b1; e.src = 2'd0; e.dst = 2'd0; end
                6'h0C: begin ralu = 1'b0; e.pc_op = 4'd7; e.cop = 32'h80; e.ck_cop = 1'b1; end
                default: ralu = 1'b0;
            endcase
            if (ralu) begin e.ck_alu = 1'b1; e.src = 2'd1; e.dst = 2'd0; e.wr = !e.ovf; end
        end else begin
            case (op)
                6'h02: e.pc_op = 4'd5;
                6'h03: begin e.pc_op = 4'd5; e.dst = 2'd2; e.src = 2'd0; e.wr = 1'b1; end
                6'h04: e.pc_op = 4'd1;
                6'h05: e.pc_op = 4'd2;
                6'h06: begin e.pc_op = 4'd4; e.rin = 1'b1; end
                6'h07: begin e.pc_op = 4'd3; e.rin = 1'b1; end
                6'h08: begin b = sx; e.alu = a + b; ialu = 1'b1;
                             e.ovf = ovf_of(longint'($signed(a)) + longint'($signed(b))); end
                6'h09: begin b = sx; e.alu = a + b; ialu = 1'b1; end
                6'h0A: begin b = sx; e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; ialu = 1'b1; end
                6'h0B: begin b = sx; e.alu = (a < b) ? 32'd1 : 32'd0; ialu = 1'b1; end
                6'h0C: begin b = {16'h0, i[15:0]}; e.alu = a & b; ialu = 1'b1; end
                6'h0D: begin b = {16'h0, i[15:0]}; e.alu = a | b; ialu = 1'b1; end
                6'h0E: begin b = {16'h0, i[15:0]}; e.alu = a ^ b; ialu = 1'b1; end
                6'h0F: begin b = {i[15:0], 16'h0}; e.alu = b; ialu = 1'b1; end
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                    b = sx; e.alu = a + b; e.ck_alu = 1'b1;
                    e.dmr = 1'b1; e.src = 2'd2; e.dst = 2'd1; e.wr = 1'b1;
                    e.dmop = (op == 6'h20) ? 3'd1 : (op == 6'h24) ? 3'd2 :
                             (op == 6'h21) ? 3'd3 : (op == 6'h25) ? 3'd4 : 3'd0;
                end
                6'h28, 6'h29, 6'h2B: begin
                    b = sx; e.alu = a + b; e.ck_alu = 1'b1; e.dmw = 1'b1;
                    e.dmop = (op == 6'h28) ? 3'd1 : (op == 6'h29) ? 3'd3 : 3'd0;
                end
                6'h10: begin
                    if (i == ERET) begin
                        e.pc_op = 4'd7; e.cop = m_cp0[14]; e.ck_cop = 1'b1;
                    end else if (i[25:21] == 5'd0) begin
                        e.cop = cp0_read(i[15:11]); e.ck_cop = 1'b1;
                        e.src = 2'd3; e.dst = 2'd1; e.wr = 1'b1;
                    end
                end
                default: ;
            endcase
            if (ialu) begin e.ck_alu = 1'b1; e.src = 2'd1; e.dst = 2'd1; e.wr = !e.ovf; end
        end
        e.zero  = (a == b);
        e.great = ($signed(a) > $signed(b));
        return e;
    endfunction

    task automatic commit(input logic r, input logic [31:0] i, input logic [31:0] rt,
                          input logic [31:0] p);
        logic [4:0] d;
        d = i[15:11];
        if (r) begin
            m_cp0[12] = '0; m_cp0[13] = '0; m_cp0[14] = '0;
        end else if (i[31:26] == 6'h00 && i[5:0] == 6'h0C) begin
            m_cp0[14] = p; m_cp0[13][6:2] = 5'd8; m_cp0[12][1] = 1'b1;
        end else if (i == ERET) begin
            m_cp0[12][1] = 1'b0;
        end else if (i[31:26] == 6'h10 && i[25:21] == 5'd4) begin
            if (d == 5'd12) m_cp0[12] = rt;
            if (d == 5'd13) m_cp0[13] = rt;
            if (d == 5'd14) m_cp0[14] = rt;
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'd0;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t tbl [9];

    initial begin
        rst = 1'b1; ins = '0; rs_data = '0; rt_data = '0; pc = '0;

        tbl[0] = mkv(enc_r(1, 2, 3, 0, 6'h21), 32'h7FFF_FFFF, 1, 32'h8000_0000, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        tbl[1] = mkv(enc_r(1, 2, 3, 0, 6'h20), 32'h7FFF_FFFF, 1, 32'h8000_0000, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        tbl[2] = mkv(enc_r(1, 2, 3, 0, 6'h22), 32'h8000_0000, 1, 32'h7FFF_FFFF, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[3] = mkv(enc_i(6'h04, 1, 2, 16'h0010), 5, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[4] = mkv(enc_i(6'h07, 1, 0, 16'h0010), 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0);
        tbl[5] = mkv(enc_i(6'h23, 1, 2, 16'hFFFC), 32'h100, 0, 32'hFC, 1, 0, 1, 0, 0, 2, 1, 0, 1, 0);
        tbl[6] = mkv(enc_i(6'h0D, 0, 2, 16'h8000), 0, 0, 32'h8000, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[7] = mkv(32'hFC00_0000, 3, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8] = mkv(enc_r(0, 2, 3, 4, 6'h03), 0, 32'h8000_0000, 32'hF800_0000, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);

        apply(1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        apply(0, enc_cop(0, 12), 0, 0, 0); chk("reset status", cop_data, 0);
        apply(0, enc_cop(0, 13), 0, 0, 0); chk("reset cause", cop_data, 0);
        apply(0, enc_cop(0, 14), 0, 0, 0); chk("reset epc", cop_data, 0);

        for (int k = 0; k < 9; k++) begin
            apply(0, tbl[k].ins, tbl[k].rs, tbl[k].rt, 0);
            if (tbl[k].ck_alu) chk($sformatf("vec%0d alu_res", k), alu_res, tbl[k].alu);
            chk($sformatf("vec%0d zero", k), zero, tbl[k].zero);
            chk($sformatf("vec%0d great", k), great, tbl[k].great);
            chk($sformatf("vec%0d overflow", k), overflow, tbl[k].ovf);
            chk($sformatf("vec%0d pc_op", k), pc_op, tbl[k].pc_op);
            chk($sformatf("vec%0d reg_wr", k), reg_wr, tbl[k].wr);
            chk($sformatf("vec%0d reg_in", k), reg_in, tbl[k].rin);
            chk($sformatf("vec%0d dm_rd", k), dm_rd, tbl[k].dmr);
            chk($sformatf("vec%0d dm_wr", k), dm_wr, tbl[k].dmw);
            if (tbl[k].wr) chk($sformatf("vec%0d reg_src", k), reg_src, tbl[k].src);
        end

        apply(0, enc_cop(4, 12), 0, 32'h1234, 0);  chk("mtc0 reg_wr", reg_wr, 0);
        apply(0, enc_cop(0, 12), 0, 0, 0);
        chk("mfc0 status", cop_data, 32'h1234);
        chk("mfc0 reg_src", reg_src, 3);
        chk("mfc0 reg_dst", reg_dst, 1);
        chk("mfc0 reg_wr", reg_wr, 1);

        apply(0, {26'd0, 6'h0C}, 0, 0, 32'h40);
        chk("syscall cop_data", cop_data, 32'h80);
        chk("syscall pc_op", pc_op, 7);
        chk("syscall reg_wr", reg_wr, 0);
        apply(0, enc_cop(0, 14), 0, 0, 0); chk("syscall epc", cop_data, 32'h40);
        apply(0, enc_cop(0, 13), 0, 0, 0); chk("syscall cause", cop_data, 32'h20);
        apply(0, enc_cop(0, 12), 0, 0, 0); chk("syscall status", cop_data, 32'h1236);

        apply(0, ERET, 0, 0, 0);
        chk("eret cop_data", cop_data, 32'h40);
        chk("eret pc_op", pc_op, 7);
        apply(0, enc_cop(0, 12), 0, 0, 0); chk("eret status", cop_data, 32'h1234);

        apply(0, enc_cop(4, 11), 0, 32'hFFFF, 0);
        apply(0, enc_cop(0, 11), 0, 0, 0); chk("cp0 r11 read", cop_data, 0);

        apply(1, enc_cop(4, 14), 0, 32'hDEAD, 0);
        apply(1, enc_r(1, 2, 3, 0, 6'h21), 2, 3, 0);
        chk("addu in reset alu_res", alu_res, 5);
        chk("addu in reset reg_wr", reg_wr, 1);
        apply(0, enc_cop(0, 14), 0, 0, 0); chk("rst vs mtc0 epc", cop_data, 0);
        apply(0, enc_cop(0, 12), 0, 0, 0); chk("rst status", cop_data, 0);

        m_cp0[12] = '0; m_cp0[13] = '0; m_cp0[14] = '0;
        for (int it = 0; it < 500; it++) begin
            logic [31:0] ri, ra, rb, rp;
            logic        rr;
            exp_t        e;
            string       tag;
            ra = rnd_opnd();
            rb = rnd_opnd();
            if ($urandom_range(0, 4) == 0) rb = ra;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ri = enc_r(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                                       r_fns[$urandom_range(0, 18)]);
                4, 5, 6:    ri = enc_i(i_ops[$urandom_range(0, 21)], 5'($urandom), 5'($urandom),
                                       16'($urandom));
                7: case ($urandom_range(0, 2))
                       0: ri = enc_cop(4, 5'($urandom_range(10, 15)));
                       1: ri = enc_cop(0, 5'($urandom_range(10, 15)));
                       default: ri = ERET;
                   endcase
                8: ri = {6'h00, 20'($urandom), 6'h0C};
                default: ri = ($urandom_range(0, 1) == 0)
                            ? enc_r(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                                    bad_fns[$urandom_range(0, 3)])
                            : enc_i(bad_ops[$urandom_range(0, 3)], 5'($urandom), 5'($urandom),
                                    16'($urandom));
            endcase
            if (ri[31:26] == 6'h06 || ri[31:26] == 6'h07) rb = 0;
            rr = ($urandom_range(0, 24) == 0);
            rp = $urandom;
            e = model(ri, ra, rb);
            apply(rr, ri, ra, rb, rp);
            tag = $sformatf("rand%0d ins=%08h", it, ri);
            if (e.ck_alu) chk({tag, " alu_res"}, alu_res, e.alu);
            chk({tag, " zero"}, zero, e.zero);
            chk({tag, " great"}, great, e.great);
            chk({tag, " overflow"}, overflow, e.ovf);
            chk({tag, " pc_op"}, pc_op, e.pc_op);
            chk({tag, " reg_wr"}, reg_wr, e.wr);
            chk({tag, " reg_in"}, reg_in, e.rin);
            chk({tag, " dm_rd"}, dm_rd, e.dmr);
            chk({tag, " dm_wr"}, dm_wr, e.dmw);
            if (e.wr) begin
                chk({tag, " reg_src"}, reg_src, e.src);
                chk({tag, " reg_dst"}, reg_dst, e.dst);
            end
            if (e.dmr || e.dmw) chk({tag, " dm_op"}, dm_op, e.dmop);
            if (e.ck_cop) chk({tag, " cop_data"}, cop_data, e.cop);
            commit(rr, ri, rb, rp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
